multicycle_alu: RTL

- Parametrised, registered successor to the processor's combinational ALU.
- Single-cycle ops: add/sub (signed and unsigned), logic, and four shift types.
- Iterative ops: signed/unsigned multiply and divide, one bit per cycle, with a 2·WIDTH product or quotient/remainder pair.
- Sits in the execute stage behind a valid/ready handshake, so the pipeline stalls only on MUL/DIV and can squash an in-flight op with `kill`.

---
 rtl/multicycle_alu.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Registered ALU for the execute stage: single-cycle add/sub/logic/shift ops and
// iterative (one bit per cycle) signed/unsigned multiply and divide.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic                     kill,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         result,
    output logic [WIDTH-1:0]         hi,
    output logic                     ovf,
    output logic                     dz
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t             state;
    logic [SHW-1:0]     cnt;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_reg;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               ovf_pend;

    logic               accept;
    logic               is_iter_op;
    logic               sgn_op;
    logic [WIDTH-1:0]   sum_add;
    logic [WIDTH-1:0]   sum_sub;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_res;
    logic [WIDTH-1:0]   fix_hi;
    logic               fix_dz;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && (state == IDLE) && !kill;
    assign is_iter_op = op[3] && op[2];
    assign sgn_op     = !op[0];

    always_comb begin
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sum_add = a + b;
        sum_sub = a - b;
        case (op)
            4'd0: begin
                sc_res = sum_add;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: sc_res = sum_add;
            4'd2: begin
                sc_res = sum_sub;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            4'd3:    sc_res = sum_sub;
            4'd4:    sc_res = a & b;
            4'd5:    sc_res = a | b;
            4'd6:    sc_res = a ^ b;
            4'd7:    sc_res = ~(a | b);
            4'd8:    sc_res = b >> shamt;
            4'd10:   sc_res = $unsigned($signed(b) >>> shamt);
            4'd9,
            4'd11:   sc_res = b << shamt;
            default: sc_res = '0;
        endcase
    end

    // One shift-add (multiply) or restoring-subtract (divide) step; acc_lo holds
    // the multiplier bits being consumed, or the dividend bits / quotient being built.
    always_comb begin
        mul_sum  = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_diff = rem_sh - {1'b0, opnd};
        step_hi  = '0;
        step_lo  = '0;
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff;
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh;
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = {1'b0, mul_sum[WIDTH:1]};
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod    = {acc_hi[WIDTH-1:0], acc_lo};
        fix_dz  = is_div && (opnd == '0);
        fix_res = '0;
        fix_hi  = '0;
        if (!is_div) begin
            if (neg_lo) prod = ~prod + 1'b1;
            fix_res = prod[WIDTH-1:0];
            fix_hi  = prod[2*WIDTH-1:WIDTH];
        end else if (fix_dz) begin
            fix_res = '1;
            fix_hi  = a_reg;
        end else begin
            fix_res = apply_sign(acc_lo, neg_lo);
            fix_hi  = apply_sign(acc_hi[WIDTH-1:0], neg_hi);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            a_reg     <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            ovf_pend  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            hi        <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !is_iter_op) begin
                        result    <= sc_res;
                        hi        <= '0;
                        ovf       <= sc_ovf;
                        dz        <= 1'b0;
                        out_valid <= 1'b1;
                    end else if (accept) begin
                        is_div   <= op[1];
                        a_reg    <= a;
                        acc_hi   <= '0;
                        acc_lo   <= magnitude(a, sgn_op);
                        opnd     <= magnitude(b, sgn_op);
                        neg_lo   <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi   <= sgn_op && a[WIDTH-1];
                        ovf_pend <= (op == 4'd14) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                        cnt      <= '0;
                        state    <= ITER;
                    end
                end
                ITER: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + SHW'(1);
                        if (cnt == SHW'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    if (!kill) begin
                        result    <= fix_res;
                        hi        <= fix_hi;
                        ovf       <= ovf_pend;
                        dz        <= fix_dz;
                        out_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
